// File: rtl/mbf_scale_cfg_master.sv
// mbf_scale_cfg_master
// Configuration initiator for the MBF FIR output-scale stages. It takes one host
// write (target index + shift value), pulses a one-hot request to the selected
// scale block, then waits for that block's done pulse or a timeout. The config
// bus holds the latched value until the next accepted write.
//
// Optional feature: define MBF_CFG_BROADCAST_EN so that Host_Sel all-ones configures
// slaves 0..NUM_SLAVES-1 in ascending order with the same data.
//
// Ports:
//   CLK, RST                      clock (rising edge), asynchronous active-high reset
//   Host_Wr/Host_Sel/Host_Data    host write strobe, target index, config value
//   Host_Ready                    1 = idle, write will be accepted
//   Host_Done/Host_Err            one-cycle completion / error (bad index, timeout) pulses
//   Last_Ack                      selected slave raised ACK during the last transaction
//   Cfg_Req/Cfg_Data              per-slave one-hot request, shared config data bus
//   Cfg_Ack/Cfg_Done              per-slave ACK level, per-slave done pulse
module mbf_scale_cfg_master #(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned CFG_WIDTH   = 24,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Host_Wr,
  input  logic [SEL_WIDTH-1:0]  Host_Sel,
  input  logic [CFG_WIDTH-1:0]  Host_Data,
  output logic                  Host_Ready,
  output logic                  Host_Done,
  output logic                  Host_Err,
  output logic                  Last_Ack,
  output logic [NUM_SLAVES-1:0] Cfg_Req,
  output logic [CFG_WIDTH-1:0]  Cfg_Data,
  input  logic [NUM_SLAVES-1:0] Cfg_Ack,
  input  logic [NUM_SLAVES-1:0] Cfg_Done
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StGap} state_e;

  state_e                state_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [CFG_WIDTH-1:0]  cfg_data_q;
  logic [NUM_SLAVES-1:0] cfg_req_q;
  logic [7:0]            cnt_q;
  logic                  host_ready_q, host_done_q, host_err_q, last_ack_q;
`ifdef MBF_CFG_BROADCAST_EN
  logic                  bcast_q;
  logic                  bcast_ack_q;  // running AND of per-slave ACKs
  logic                  last_slave;
`endif

  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  ack_sel, done_sel, host_sel_ok, timeout;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_WIDTH-1:0] s);
    logic [NUM_SLAVES-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      oh[i] = (s == SEL_WIDTH'(i));
    end
    return oh;
  endfunction

  always_comb begin
    sel_oh      = onehot(sel_q);
    // Masking avoids indexing with a select that may be wider than the slave count.
    ack_sel     = |(Cfg_Ack & sel_oh);
    done_sel    = |(Cfg_Done & sel_oh);
    host_sel_ok = 32'(Host_Sel) < NUM_SLAVES;
    timeout     = (cnt_q == 8'(TIMEOUT_CYC - 1));
`ifdef MBF_CFG_BROADCAST_EN
    last_slave  = (sel_q == SEL_WIDTH'(NUM_SLAVES - 1));
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      cfg_data_q   <= '0;
      cfg_req_q    <= '0;
      cnt_q        <= '0;
      host_ready_q <= 1'b1;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      last_ack_q   <= 1'b0;
`ifdef MBF_CFG_BROADCAST_EN
      bcast_q      <= 1'b0;
      bcast_ack_q  <= 1'b0;
`endif
    end else begin
      // Pulse-type outputs default low each cycle.
      host_done_q <= 1'b0;
      host_err_q  <= 1'b0;
      cfg_req_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (Host_Wr) begin
`ifdef MBF_CFG_BROADCAST_EN
            if (&Host_Sel) begin
              bcast_q      <= 1'b1;
              bcast_ack_q  <= 1'b1;
              sel_q        <= '0;
              cfg_data_q   <= Host_Data;
              cfg_req_q    <= onehot('0);
              host_ready_q <= 1'b0;
              state_q      <= StReq;
            end else
`endif
            if (host_sel_ok) begin
`ifdef MBF_CFG_BROADCAST_EN
              bcast_q      <= 1'b0;
`endif
              sel_q        <= Host_Sel;
              cfg_data_q   <= Host_Data;
              cfg_req_q    <= onehot(Host_Sel);
              host_ready_q <= 1'b0;
              state_q      <= StReq;
            end else begin
              host_err_q   <= 1'b1;
            end
          end
        end
        StReq: begin
          cnt_q      <= '0;
          last_ack_q <= 1'b0;
          state_q    <= StWait;
        end
        StWait: begin
          if (ack_sel) last_ack_q <= 1'b1;
          // Done takes priority over a coincident timeout.
          if (done_sel || timeout) begin
            state_q <= StGap;
            if (done_sel) begin
`ifdef MBF_CFG_BROADCAST_EN
              host_done_q <= !bcast_q || last_slave;
`else
              host_done_q <= 1'b1;
`endif
            end else begin
              host_err_q <= 1'b1;
            end
`ifdef MBF_CFG_BROADCAST_EN
            if (bcast_q) begin
              last_ack_q  <= bcast_ack_q & (last_ack_q | ack_sel);
              bcast_ack_q <= bcast_ack_q & (last_ack_q | ack_sel);
            end
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
`ifdef MBF_CFG_BROADCAST_EN
          // host_err_q set here means the previous slave timed out: stop the sweep.
          if (bcast_q && !host_err_q && !last_slave) begin
            sel_q     <= sel_q + SEL_WIDTH'(1);
            cfg_req_q <= onehot(sel_q + SEL_WIDTH'(1));
            state_q   <= StReq;
          end else begin
            bcast_q      <= 1'b0;
            host_ready_q <= 1'b1;
            state_q      <= StIdle;
          end
`else
          host_ready_q <= 1'b1;
          state_q      <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Host_Ready = host_ready_q;
  assign Host_Done  = host_done_q;
  assign Host_Err   = host_err_q;
  assign Last_Ack   = last_ack_q;
  assign Cfg_Req    = cfg_req_q;
  assign Cfg_Data   = cfg_data_q;

endmodule

// File: tb/tb_mbf_scale_cfg_master.sv
module tb_mbf_scale_cfg_master;

  localparam int unsigned NS  = 4;
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 24;
  localparam int unsigned TMO = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Host_Wr = 1'b0;
  logic [SW-1:0] Host_Sel = '0;
  logic [CW-1:0] Host_Data = '0;
  logic          Host_Ready, Host_Done, Host_Err, Last_Ack;
  logic [NS-1:0] Cfg_Req;
  logic [CW-1:0] Cfg_Data;
  logic [NS-1:0] Cfg_Ack = '0;
  logic [NS-1:0] Cfg_Done = '0;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] slave_reg [NS];

  mbf_scale_cfg_master #(
    .NUM_SLAVES (NS),
    .SEL_WIDTH  (SW),
    .CFG_WIDTH  (CW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Host_Wr   (Host_Wr),
    .Host_Sel  (Host_Sel),
    .Host_Data (Host_Data),
    .Host_Ready(Host_Ready),
    .Host_Done (Host_Done),
    .Host_Err  (Host_Err),
    .Last_Ack  (Last_Ack),
    .Cfg_Req   (Cfg_Req),
    .Cfg_Data  (Cfg_Data),
    .Cfg_Ack   (Cfg_Ack),
    .Cfg_Done  (Cfg_Done)
  );

  always #5 CLK = ~CLK;

  // Slave model: each scale block captures the bus while its request is high.
  always @(posedge CLK) begin
    for (int i = 0; i < int'(NS); i++) begin
      if (Cfg_Req[i]) slave_reg[i] <= Cfg_Data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int errs;
    int err_cyc;
    int dones;
    int stray;
    for (int i = 0; i < int'(NS); i++) slave_reg[i] = '0;

    tick();
    tick();
    RST = 1'b0;
    // Reset state
    check_eq("rst_ready", 32'(Host_Ready), 32'd1);
    check_eq("rst_done",  32'(Host_Done),  32'd0);
    check_eq("rst_err",   32'(Host_Err),   32'd0);
    check_eq("rst_lack",  32'(Last_Ack),   32'd0);
    check_eq("rst_req",   32'(Cfg_Req),    32'd0);
    check_eq("rst_data",  32'(Cfg_Data),   32'd0);

    // 1: sel=2 data=5, ACK at cycle 2, done at cycle 4
    Host_Wr = 1'b1; Host_Sel = 4'd2; Host_Data = 24'h000005;
    tick();  // cycle 1
    Host_Wr = 1'b0;
    check_eq("t1_req",   32'(Cfg_Req),    32'h4);
    check_eq("t1_data",  32'(Cfg_Data),   32'h5);
    check_eq("t1_ready", 32'(Host_Ready), 32'd0);
    tick();  // cycle 2
    Cfg_Ack = 4'b0100;
    check_eq("t1_req_drop", 32'(Cfg_Req), 32'h0);
    tick();  // cycle 3
    Cfg_Ack = '0;
    tick();  // cycle 4
    Cfg_Done = 4'b0100;
    check_eq("t1_no_early_done", 32'(Host_Done), 32'd0);
    tick();  // cycle 5
    Cfg_Done = '0;
    check_eq("t1_done",  32'(Host_Done),  32'd1);
    check_eq("t1_lack",  32'(Last_Ack),   32'd1);
    check_eq("t1_err",   32'(Host_Err),   32'd0);
    check_eq("t1_gap_ready", 32'(Host_Ready), 32'd0);
    tick();  // cycle 6
    check_eq("t1_ready_back", 32'(Host_Ready), 32'd1);
    check_eq("t1_done_pulse", 32'(Host_Done),  32'd0);
    check_eq("t1_slave", 32'(slave_reg[2]), 32'h5);

    // 2: reconfigure sel=2 data=3, done without ACK
    Host_Wr = 1'b1; Host_Sel = 4'd2; Host_Data = 24'h000003;
    tick();  // 1
    Host_Wr = 1'b0;
    tick();  // 2
    tick();  // 3
    tick();  // 4
    Cfg_Done = 4'b0100;
    tick();  // 5
    Cfg_Done = '0;
    check_eq("t2_done", 32'(Host_Done), 32'd1);
    check_eq("t2_lack", 32'(Last_Ack),  32'd0);
    check_eq("t2_err",  32'(Host_Err),  32'd0);
    tick();
    check_eq("t2_slave", 32'(slave_reg[2]), 32'h3);

    // 3: sel=1, slave never completes -> single timeout error at cycle TMO+2
    Host_Wr = 1'b1; Host_Sel = 4'd1; Host_Data = 24'h0000AA;
    errs = 0; err_cyc = 0; dones = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      Host_Wr = 1'b0;
      if (Host_Err) begin
        errs++;
        if (err_cyc == 0) err_cyc = c;
      end
      if (Host_Done) dones++;
    end
    check_eq("t3_err_count", 32'(errs),       32'd1);
    check_eq("t3_err_cycle", 32'(err_cyc),    32'(TMO + 2));
    check_eq("t3_no_done",   32'(dones),      32'd0);
    check_eq("t3_ready",     32'(Host_Ready), 32'd1);

    // 4: out-of-range sel=7
    Host_Wr = 1'b1; Host_Sel = 4'd7; Host_Data = 24'h000077;
    tick();
    Host_Wr = 1'b0;
    check_eq("t4_err",   32'(Host_Err),   32'd1);
    check_eq("t4_req",   32'(Cfg_Req),    32'h0);
    check_eq("t4_ready", 32'(Host_Ready), 32'd1);
    check_eq("t4_data",  32'(Cfg_Data),   32'hAA);
    tick();
    check_eq("t4_err_pulse", 32'(Host_Err), 32'd0);
    check_eq("t4_req2",      32'(Cfg_Req),  32'h0);

    // 5: Host_Wr held during the transaction with sel=3; stray done from slave 3
    Host_Wr = 1'b1; Host_Sel = 4'd2; Host_Data = 24'h000011;
    tick();  // 1
    Host_Sel = 4'd3; Host_Data = 24'h000022;
    check_eq("t5_req", 32'(Cfg_Req), 32'h4);
    stray = 0;
    tick();  // 2
    if (Cfg_Req != '0) stray++;
    tick();  // 3
    if (Cfg_Req != '0) stray++;
    Cfg_Done = 4'b1000;
    tick();  // 4
    if (Cfg_Req != '0) stray++;
    Cfg_Done = 4'b0100;
    check_eq("t5_other_done_ignored", 32'(Host_Done), 32'd0);
    check_eq("t5_data_hold", 32'(Cfg_Data), 32'h11);
    tick();  // 5
    Cfg_Done = '0;
    Host_Wr  = 1'b0;
    check_eq("t5_done", 32'(Host_Done), 32'd1);
    check_eq("t5_err",  32'(Host_Err),  32'd0);
    tick();  // 6
    check_eq("t5_stray_req", 32'(stray),        32'd0);
    check_eq("t5_slave2",    32'(slave_reg[2]), 32'h11);
    check_eq("t5_slave3",    32'(slave_reg[3]), 32'h0);
    check_eq("t5_ready",     32'(Host_Ready),   32'd1);

    // 6: reset asserted mid-transaction
    Host_Wr = 1'b1; Host_Sel = 4'd0; Host_Data = 24'h000033;
    tick();  // 1, request in flight
    Host_Wr = 1'b0;
    check_eq("t6_req", 32'(Cfg_Req), 32'h1);
    RST = 1'b1;
    #1;
    check_eq("t6_req_async", 32'(Cfg_Req),    32'h0);
    check_eq("t6_ready",     32'(Host_Ready), 32'd1);
    check_eq("t6_data",      32'(Cfg_Data),   32'h0);
    Cfg_Done = 4'b0001;
    tick();
    tick();
    RST = 1'b0;
    Cfg_Done = '0;
    dones = 0; errs = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (Host_Done) dones++;
      if (Host_Err) errs++;
    end
    check_eq("t6_no_done", 32'(dones),      32'd0);
    check_eq("t6_no_err",  32'(errs),       32'd0);
    check_eq("t6_ready2",  32'(Host_Ready), 32'd1);

`ifdef MBF_CFG_BROADCAST_EN
    // 7: broadcast sel=F data=2, each slave ACKs and completes on its first WAIT cycle
    Host_Wr = 1'b1; Host_Sel = 4'hF; Host_Data = 24'h000002;
    dones = 0;
    for (int k = 0; k < int'(NS); k++) begin
      int waited;
      waited = 0;
      tick();
      Host_Wr = 1'b0;
      if (Host_Done) dones++;
      while (Cfg_Req == '0 && waited < 10) begin
        tick();
        if (Host_Done) dones++;
        waited++;
      end
      check_eq("t7_req_onehot", 32'(Cfg_Req), 32'(1) << k);
      tick();
      Cfg_Ack = 4'(1 << k); Cfg_Done = 4'(1 << k);
      tick();
      Cfg_Ack = '0; Cfg_Done = '0;
      if (Host_Done) dones++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (Host_Done) dones++;
    end
    check_eq("t7_done_once", 32'(dones),        32'd1);
    check_eq("t7_lack",      32'(Last_Ack),     32'd1);
    check_eq("t7_slave0",    32'(slave_reg[0]), 32'h2);
    check_eq("t7_slave3",    32'(slave_reg[3]), 32'h2);
    check_eq("t7_ready",     32'(Host_Ready),   32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
